// File: rtl/hyp_range_reduce.sv
// hyp_range_reduce: range reduction ahead of the hyperbolic CORDIC.
// Splits a wide signed Q.14 angle into ang = k*ln2 + r with |r| <= ln2/2.
// r feeds the CORDIC angle port as Q2.14; k is the power-of-two rebuild count.
// Optional build macro HRR_QUAD_STEP_EN adds a 4*ln2 step to shorten long reductions.
module hyp_range_reduce #(
   parameter int IN_W     = 20,
   parameter int K_W      = 7,
   parameter int LN2      = 11357,
   parameter int HALF_LN2 = 5678
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [IN_W-1:0] ang_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [15:0]    r_out,
   output logic signed [K_W-1:0] k_out,
   output logic                  busy
);

   localparam int ACC_W = IN_W + 1;

   localparam logic signed [ACC_W-1:0] LN2_A      = ACC_W'(LN2);
   localparam logic signed [ACC_W-1:0] HALF_A     = ACC_W'(HALF_LN2);
   localparam logic signed [ACC_W-1:0] NEG_HALF_A = -HALF_A;
   localparam logic signed [K_W-1:0]   K_ONE      = K_W'(1);

`ifdef HRR_QUAD_STEP_EN
   localparam logic signed [ACC_W-1:0] QUAD_LN2_A     = ACC_W'(4 * LN2);
   localparam logic signed [ACC_W-1:0] QUAD_THR_A     = ACC_W'(4 * LN2 + HALF_LN2);
   localparam logic signed [ACC_W-1:0] NEG_QUAD_THR_A = -QUAD_THR_A;
   localparam logic signed [K_W-1:0]   K_FOUR         = K_W'(4);
`endif

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      DONE
   } state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic signed [K_W-1:0]   k;

   // Handshake and status flags depend only on the registered state
   assign in_ready = (state == IDLE);
   assign busy     = (state == REDUCE);

   // Accept an operand, peel off ln2 multiples one decision per cycle, then hold the result
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         acc       <= '0;
         k         <= '0;
         r_out     <= '0;
         k_out     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc   <= {ang_in[IN_W-1], ang_in};
                  k     <= '0;
                  state <= REDUCE;
               end
            end
            REDUCE: begin
`ifdef HRR_QUAD_STEP_EN
               if (acc > QUAD_THR_A) begin
                  acc <= acc - QUAD_LN2_A;
                  k   <= k + K_FOUR;
               end else if (acc < NEG_QUAD_THR_A) begin
                  acc <= acc + QUAD_LN2_A;
                  k   <= k - K_FOUR;
               end else
`endif
               if (acc > HALF_A) begin
                  acc <= acc - LN2_A;
                  k   <= k + K_ONE;
               end else if (acc < NEG_HALF_A) begin
                  acc <= acc + LN2_A;
                  k   <= k - K_ONE;
               end else begin
                  r_out     <= acc[15:0];
                  k_out     <= k;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hyp_range_reduce.sv
// tb_hyp_range_reduce: self-checking bench for hyp_range_reduce.
// Directed corner angles plus random angles are compared against an arithmetic
// model of ang = k*ln2 + r; latency expectations follow HRR_QUAD_STEP_EN if defined.
module tb_hyp_range_reduce;

   localparam int IN_W     = 20;
   localparam int K_W      = 7;
   localparam int LN2      = 11357;
   localparam int HALF_LN2 = 5678;
   localparam int QUAD_THR = 4 * LN2 + HALF_LN2;

   logic                   clk;
   logic                   reset;
   logic                   in_valid;
   logic                   in_ready;
   logic signed [IN_W-1:0] ang_in;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [15:0]     r_out;
   logic signed [K_W-1:0]  k_out;
   logic                   busy;

   int checks   = 0;
   int failures = 0;

   hyp_range_reduce #(
      .IN_W     (IN_W),
      .K_W      (K_W),
      .LN2      (LN2),
      .HALF_LN2 (HALF_LN2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ang_in    (ang_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r_out     (r_out),
      .k_out     (k_out),
      .busy      (busy)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it if observed differs from expected
   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference: the unique k with |ang - k*ln2| <= ln2/2, plus the expected step count
   task automatic refModel(input int a, output int r, output int k, output int lat);
      int m;
      int km;
      int q;
      int steps;
      m  = (a < 0) ? -a : a;
      km = 0;
      q  = 0;
      if (m > HALF_LN2)
         km = (m - HALF_LN2 + LN2 - 1) / LN2;
`ifdef HRR_QUAD_STEP_EN
      if (m > QUAD_THR)
         q = (m - QUAD_THR + 4 * LN2 - 1) / (4 * LN2);
`endif
      steps = km - 3 * q;
      k     = (a < 0) ? -km : km;
      r     = a - k * LN2;
      lat   = steps + 1;
   endtask

   task automatic advance(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait for out_valid after an accept edge; returns edges counted, bounded
   task automatic waitResult(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 200) begin
         advance(1);
         cycles++;
      end
   endtask

   // Push one operand through, check result, latency, and optional backpressure hold
   task automatic applyStimulus(input int a, input int hold);
      int er, ek, elat, lat;
      logic signed [15:0]    r_seen;
      logic signed [K_W-1:0] k_seen;
      refModel(a, er, ek, elat);
      checkOutput("in_ready_idle", longint'(in_ready), 1);
      in_valid = 1'b1;
      ang_in   = IN_W'(a);
      advance(1);
      in_valid = 1'b0;
      ang_in   = IN_W'($urandom);
      checkOutput("busy_after_accept", longint'(busy), 1);
      waitResult(lat);
      checkOutput($sformatf("latency(%0d)", a), lat, elat);
      checkOutput($sformatf("r(%0d)", a), longint'(r_out), er);
      checkOutput($sformatf("k(%0d)", a), longint'(k_out), ek);
      checkOutput("busy_done", longint'(busy), 0);
      r_seen = r_out;
      k_seen = k_out;
      for (int i = 0; i < hold; i++) begin
         advance(1);
         checkOutput("hold_valid", longint'(out_valid), 1);
         checkOutput("hold_r", longint'(r_out), longint'(r_seen));
         checkOutput("hold_k", longint'(k_out), longint'(k_seen));
      end
      out_ready = 1'b1;
      advance(1);
      out_ready = 1'b0;
      checkOutput("valid_cleared", longint'(out_valid), 0);
      checkOutput("in_ready_back", longint'(in_ready), 1);
   endtask

   int dirList[] = '{7596, 0, 5678, -5678, -20000, 524287, -524288, 5679, -5679,
                     51106, 51107, -51107, 17035, -17036};

   initial begin
      int er, ek, elat, lat, pulses;
      int first_a, second_a;
      logic [IN_W-1:0] rnd;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ang_in    = '0;

      // Reset held low for two edges
      advance(2);
      reset = 1'b1;
      checkOutput("rst_out_valid", longint'(out_valid), 0);
      checkOutput("rst_r_out", longint'(r_out), 0);
      checkOutput("rst_k_out", longint'(k_out), 0);
      checkOutput("rst_busy", longint'(busy), 0);
      checkOutput("rst_in_ready", longint'(in_ready), 1);

      // Directed angles, then random full-range angles
      foreach (dirList[i])
         applyStimulus(dirList[i], (i % 3));
      for (int i = 0; i < 25; i++) begin
         rnd = IN_W'($urandom);
         applyStimulus(int'($signed(rnd)), int'($urandom_range(0, 2)));
      end

      // Reset in the middle of a long reduction discards the operand
      in_valid = 1'b1;
      ang_in   = IN_W'(400000);
      advance(1);
      in_valid = 1'b0;
      advance(5);
      checkOutput("midrst_busy_before", longint'(busy), 1);
      reset = 1'b0;
      advance(1);
      reset = 1'b1;
      checkOutput("midrst_in_ready", longint'(in_ready), 1);
      checkOutput("midrst_busy", longint'(busy), 0);
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         if (out_valid) pulses++;
         advance(1);
      end
      checkOutput("midrst_no_pulse", pulses, 0);

      // Backpressure with a second operand already waiting on the input
      first_a  = -20000;
      second_a = 7596;
      in_valid = 1'b1;
      ang_in   = IN_W'(first_a);
      advance(1);
      ang_in = IN_W'(second_a);
      waitResult(lat);
      refModel(first_a, er, ek, elat);
      checkOutput("bp_latency", lat, elat);
      for (int i = 0; i < 5; i++) begin
         advance(1);
         checkOutput("bp_valid", longint'(out_valid), 1);
         checkOutput("bp_in_ready", longint'(in_ready), 0);
         checkOutput("bp_r", longint'(r_out), er);
         checkOutput("bp_k", longint'(k_out), ek);
      end
      out_ready = 1'b1;
      advance(1);
      out_ready = 1'b0;
      checkOutput("bp_idle_in_ready", longint'(in_ready), 1);
      checkOutput("bp_idle_busy", longint'(busy), 0);
      advance(1);
      in_valid = 1'b0;
      checkOutput("bp_second_accepted", longint'(busy), 1);
      waitResult(lat);
      refModel(second_a, er, ek, elat);
      checkOutput("bp2_latency", lat, elat);
      checkOutput("bp2_r", longint'(r_out), er);
      checkOutput("bp2_k", longint'(k_out), ek);
      out_ready = 1'b1;
      advance(1);
      out_ready = 1'b0;
      checkOutput("bp2_cleared", longint'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hyp_range_reduce.md
# hyp_range_reduce

Argument range-reduction stage feeding the hyperbolic CORDIC (`cordic_2taylor`) `ang` port.
- Takes a wide signed angle and iteratively removes multiples of ln2: ang = k·ln2 + r, with |r| ≤ ln2/2, which is inside hyperbolic CORDIC convergence.
- Emits r as a 16-bit Q2.14 angle and k as a signed shift count. A downstream stage rebuilds e^ang = 2^k·(cosh r + sinh r).
- Valid/ready on both sides; one operand in flight.

## Interface
- `IN_W`, 20, input angle width, signed Q(IN_W-14).14; default Q6.14, range [-32, 32)
- `K_W`, 7, width of signed k output
- `LN2`, 11357 (0x2C5D), ln2 in Q.14
- `HALF_LN2`, 5678 (0x162E), ln2/2 in Q.14
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge
- `in_valid`  in  1  operand present
- `in_ready`  out  1  block can accept (high only in IDLE)
- `ang_in`  in  IN_W  signed Q.14 angle
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `r_out`  out  16  signed Q2.14 reduced angle, to CORDIC `ang`
- `k_out`  out  K_W  signed count of ln2 removed
- `busy`  out  1  high in REDUCE

## Operation
- FSM has three states: IDLE, REDUCE and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, load the accumulator acc←ang_in (IN_W+1 bits signed), set k←0, and go to REDUCE.
- REDUCE, one decision per cycle:
  - acc > HALF_LN2: acc←acc−LN2, k←k+1.
  - acc < −HALF_LN2: acc←acc+LN2, k←k−1.
  - Otherwise: r_out←acc[15:0], k_out←k, out_valid←1, go to DONE.
- Boundaries are inclusive: acc = ±HALF_LN2 is final (r = ±5678).
- DONE:
  - Hold `r_out`, `k_out` and `out_valid` until `out_ready`=1.
  - Then clear `out_valid` and go to IDLE.
- No new accept in the same cycle as the DONE→IDLE transition.
- Arithmetic is exact two's-complement with no rounding. r_out is always within [−5678, 5678], so it fits Q2.14 without saturation.
- Over the default input range |k| ≤ 47, which fits K_W=7.
- `ang_in` is sampled only on the accept edge; later changes are ignored.

## Timing
- Reset (`reset`=0 at an edge) forces:
  - state=IDLE, `out_valid`=0, `r_out`=0, `k_out`=0, `busy`=0
  - `in_ready`=1 from the first cycle after reset is released
- Reset mid-REDUCE or mid-DONE discards the operand; no result is emitted.
- Latency, counted from the accept edge to the edge that raises `out_valid`, is (number of REDUCE steps)+1:
  - Default build: |k|+1.
  - k=0 gives `out_valid` one cycle after accept.
- `out_valid` stays high while `out_ready`=0; outputs remain stable.
- `in_ready`, `out_valid` and `busy` are functions of state only. There are no combinational paths from `in_valid` or `out_ready` to them.

## Configuration
- `HRR_QUAD_STEP_EN`
  - Defined: REDUCE first checks acc > 4·LN2+HALF_LN2 (51106), which subtracts 4·LN2 (45428) and sets k+4. It also checks acc < −51106, which adds 45428 and sets k−4. Otherwise the single-step rules apply.
  - The final r and k are identical to the undefined build; only the REDUCE step count shrinks.
  - Undefined: single-step only; the 4·LN2 comparators and adders are not instantiated.

## Test plan
- Reset behaviour: hold `reset`=0 for 2 cycles, then release.
  - Required: `out_valid`=0, `r_out`=0, `k_out`=0, `busy`=0, `in_ready`=1.
  - Then repeat with a reset asserted mid-REDUCE.
  - Required: return to IDLE, no `out_valid` pulse.
- Small angle: `ang_in`=0x01DAC (7596), `out_ready`=1.
  - Required: `r_out`=−3761 (0xF14F), `k_out`=1.
  - Required: `out_valid` 2 cycles after accept.
- In-range inputs, no reduction:
  - `ang_in`=0 → r=0, k=0, latency 1.
  - `ang_in`=5678 → r=5678, k=0.
  - `ang_in`=−5678 → r=−5678, k=0.
- Negative angle: `ang_in`=−20000.
  - Required: r=2714, k=−2, latency 3.
- Maximum input: `ang_in`=0x7FFFF (524287).
  - Required in both builds: r=1865, k=46.
  - Latency is 47 without the macro and 14 with `HRR_QUAD_STEP_EN`.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`, while `in_valid`=1 with a new operand.
  - Required: outputs stable, `in_ready`=0.
  - Required: the first result is consumed on `out_ready`; the second operand is accepted the cycle after returning to IDLE.
